// File: rtl/pixel_combinator.sv
// pixel_combinator
//   Raster-order merge stage sitting behind the per-engine pixel queues.
//   Each screen coordinate is presented once per frame on the check bus; the
//   lowest-index queue whose front entry matches supplies the colour, and
//   after TIMEOUT search cycles without a match the background colour is
//   emitted instead. Pixels leave on a valid/ready stream with sop/eol/eop.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   start           begin a frame (sampled only while idle)
//   en, match       per-queue non-empty / front-matches-check-coordinate
//   colour_i        per-queue front colour, queue i at [i*RBG_SIZE +: RBG_SIZE]
//   xpixel_check    coordinate being searched (parked at IMAGE_W when idle)
//   ypixel_check    coordinate being searched (parked at IMAGE_H when idle)
//   pop             one-hot, one-cycle consume strobe to the matching queue
//   out_data        pixel colour
//   out_valid       out_data valid; out_ready is the downstream accept
//   out_sop/eol/eop frame start, end of line, end of frame markers
//   frame_done      one-cycle pulse after the last pixel handshake
//   timeout_cnt     saturating count of background pixels in this frame
module pixel_combinator #(
  parameter int NUM_QUEUES = 4,
  parameter int DATA_WIDTH = 10,
  parameter int RBG_SIZE   = 24,
  parameter int IMAGE_W    = 640,
  parameter int IMAGE_H    = 480,
  parameter int TIMEOUT    = 255,
  parameter logic [RBG_SIZE-1:0] BG_COLOUR = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_QUEUES-1:0]          en,
  input  logic [NUM_QUEUES-1:0]          match,
  input  logic [NUM_QUEUES*RBG_SIZE-1:0] colour_i,
  output logic [DATA_WIDTH-1:0]          xpixel_check,
  output logic [DATA_WIDTH-1:0]          ypixel_check,
  output logic [NUM_QUEUES-1:0]          pop,
  output logic [RBG_SIZE-1:0]            out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_sop,
  output logic                           out_eol,
  output logic                           out_eop,
  output logic                           frame_done,
  output logic [15:0]                    timeout_cnt
);

  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] X_LAST    = DATA_WIDTH'(IMAGE_W - 1);
  localparam logic [DATA_WIDTH-1:0] Y_LAST    = DATA_WIDTH'(IMAGE_H - 1);
  localparam logic [DATA_WIDTH-1:0] X_PARK    = DATA_WIDTH'(IMAGE_W);
  localparam logic [DATA_WIDTH-1:0] Y_PARK    = DATA_WIDTH'(IMAGE_H);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    HOLD   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   x;
  logic [DATA_WIDTH-1:0]   y;
  logic [WAIT_W-1:0]       wait_cnt;

  logic                    hit;
  logic [NUM_QUEUES-1:0]   sel_pop;
  logic [RBG_SIZE-1:0]     sel_colour;
  logic                    at_sop;
  logic                    at_eol;
  logic                    at_eop;

  // Background-pixel counter must stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Lowest-index priority select. Scanning from the top down lets the last
  // assignment win, so the lowest valid index ends up selected.
  always_comb begin
    hit        = 1'b0;
    sel_pop    = '0;
    sel_colour = '0;
    for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
      if (match[i] && en[i]) begin
        hit        = 1'b1;
        sel_pop    = '0;
        sel_pop[i] = 1'b1;
        sel_colour = colour_i[i*RBG_SIZE +: RBG_SIZE];
      end
    end
  end

  // The parked coordinate lies outside the image, so no queue front (real
  // data or an empty queue's all-ones entry) can match it while we are not
  // actively searching.
  assign xpixel_check = (state == SEARCH) ? x : X_PARK;
  assign ypixel_check = (state == SEARCH) ? y : Y_PARK;

  // pop must reach the queue in the same cycle the match is seen so the
  // queue advances before the next coordinate is presented; hence it is
  // decoded from the registered state rather than registered itself.
  assign pop = (state == SEARCH && !reset) ? sel_pop : '0;

  assign at_sop = (x == '0) && (y == '0);
  assign at_eol = (x == X_LAST);
  assign at_eop = (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      wait_cnt    <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_sop     <= 1'b0;
      out_eol     <= 1'b0;
      out_eop     <= 1'b0;
      frame_done  <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= SEARCH;
            wait_cnt    <= '0;
            timeout_cnt <= '0;
          end
        end

        SEARCH: begin
          if (hit || (wait_cnt == WAIT_LAST)) begin
            out_data  <= hit ? sel_colour : BG_COLOUR;
            out_valid <= 1'b1;
            out_sop   <= at_sop;
            out_eol   <= at_eol;
            out_eop   <= at_eop;
            state     <= HOLD;
            if (!hit) begin
              timeout_cnt <= sat_inc16(timeout_cnt);
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eol   <= 1'b0;
            out_eop   <= 1'b0;
            if (at_eop) begin
              x          <= '0;
              y          <= '0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              if (at_eol) begin
                x <= '0;
                y <= y + DATA_WIDTH'(1);
              end else begin
                x <= x + DATA_WIDTH'(1);
              end
              wait_cnt <= '0;
              state    <= SEARCH;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_combinator.sv
module tb_pixel_combinator;

  localparam int NQ  = 4;
  localparam int DW  = 10;
  localparam int RBG = 24;
  localparam int IW  = 4;
  localparam int IH  = 2;
  localparam int TO  = 5;
  localparam logic [23:0] BG = 24'h123456;
  localparam logic [9:0] XP = 10'd4;
  localparam logic [9:0] YP = 10'd2;

  logic              clk;
  logic              reset;
  logic              start;
  logic [NQ-1:0]     en;
  logic [NQ-1:0]     match;
  logic [NQ*RBG-1:0] colour_i;
  logic [DW-1:0]     xpixel_check;
  logic [DW-1:0]     ypixel_check;
  logic [NQ-1:0]     pop;
  logic [RBG-1:0]    out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sop;
  logic              out_eol;
  logic              out_eop;
  logic              frame_done;
  logic [15:0]       timeout_cnt;

  pixel_combinator #(
    .NUM_QUEUES(NQ), .DATA_WIDTH(DW), .RBG_SIZE(RBG),
    .IMAGE_W(IW), .IMAGE_H(IH), .TIMEOUT(TO), .BG_COLOUR(BG)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .en(en), .match(match),
    .colour_i(colour_i), .xpixel_check(xpixel_check), .ypixel_check(ypixel_check),
    .pop(pop), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eol(out_eol), .out_eop(out_eop),
    .frame_done(frame_done), .timeout_cnt(timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Per-coordinate raw match pattern presented by the queue responder.
  logic [NQ-1:0] match_tab [0:IW*IH-1];
  int resp_idx;

  function automatic logic [23:0] colour_fn(input int q, input logic [9:0] x, input logic [9:0] y);
    return {8'hA0 + 8'(q), x[7:0], y[7:0]};
  endfunction

  // Queue responder: fronts compare against the check bus combinationally.
  always_comb begin
    match    = '0;
    colour_i = '0;
    resp_idx = 0;
    for (int q = 0; q < NQ; q++) colour_i[q*RBG +: RBG] = colour_fn(q, xpixel_check, ypixel_check);
    if (xpixel_check < 10'(IW) && ypixel_check < 10'(IH)) begin
      resp_idx = int'(ypixel_check) * IW + int'(xpixel_check);
      match    = match_tab[resp_idx];
    end
  end

  typedef struct {
    logic [23:0] data;
    logic        sop;
    logic        eol;
    logic        eop;
    logic [3:0]  pop;
    int          gap;
  } exp_t;

  exp_t sb[$];
  int   exp_timeouts;

  task automatic fill_tab(input logic [3:0] v);
    for (int i = 0; i < IW*IH; i++) match_tab[i] = v;
  endtask

  // Reference model: push the whole frame's expected pixel stream.
  task automatic build_expected();
    exp_t e;
    logic [3:0] m;
    bit found;
    sb.delete();
    exp_timeouts = 0;
    for (int y = 0; y < IH; y++) begin
      for (int x = 0; x < IW; x++) begin
        m      = match_tab[y*IW + x] & en;
        found  = 1'b0;
        e.pop  = '0;
        e.data = BG;
        for (int q = 0; q < NQ; q++) begin
          if (!found && m[q]) begin
            found    = 1'b1;
            e.pop[q] = 1'b1;
            e.data   = colour_fn(q, 10'(x), 10'(y));
          end
        end
        if (!found) exp_timeouts++;
        e.sop = (x == 0 && y == 0);
        e.eol = (x == IW - 1);
        e.eop = (x == IW - 1) && (y == IH - 1);
        e.gap = found ? 2 : TO + 1;
        sb.push_back(e);
      end
    end
  endtask

  // Starts a frame and compares every handshake against the scoreboard.
  // stall_idx >= 0 holds out_ready low for 10 cycles on that pixel.
  task automatic drain_frame(input int stall_idx, input string tag);
    int cyc = 0, hs = 0, last_hs = 0, stall_left, stall_cyc = 0, pop_cnt = 0;
    logic [3:0]  pop_acc = '0;
    bit          done_seen = 1'b0;
    logic [23:0] cap_data = '0;
    logic [2:0]  cap_mk = '0;
    exp_t e;
    stall_left = (stall_idx >= 0) ? 10 : 0;
    start = 1'b1;
    while (!done_seen && cyc < 400) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (pop !== 4'b0) begin
        pop_acc |= pop;
        pop_cnt++;
      end
      out_ready = !(hs == stall_idx && stall_left > 0);
      if (frame_done) begin
        done_seen = 1'b1;
        tests_run++;
        if (sb.size() != 0) begin
          tests_failed++;
          $display("FAIL %s frame_done early: %0d pixels still expected, required 0", tag, sb.size());
        end
        tests_run++;
        if (cyc - last_hs != 1) begin
          tests_failed++;
          $display("FAIL %s frame_done delay: got %0d cycles after last handshake, required 1", tag, cyc - last_hs);
        end
        tests_run++;
        if (timeout_cnt !== 16'(exp_timeouts)) begin
          tests_failed++;
          $display("FAIL %s timeout_cnt: got %0d required %0d", tag, timeout_cnt, exp_timeouts);
        end
      end else if (out_valid) begin
        if (!out_ready) begin
          if (stall_cyc == 0) begin
            cap_data = out_data;
            cap_mk   = {out_sop, out_eol, out_eop};
          end else begin
            tests_run++;
            if (out_data !== cap_data || {out_sop, out_eol, out_eop} !== cap_mk) begin
              tests_failed++;
              $display("FAIL %s stall stability: got data %h markers %b, required %h %b", tag, out_data, {out_sop, out_eol, out_eop}, cap_data, cap_mk);
            end
          end
          tests_run++;
          if (xpixel_check !== XP || ypixel_check !== YP || pop !== 4'b0) begin
            tests_failed++;
            $display("FAIL %s stall park/pop: got (%0d,%0d) pop %b, required (%0d,%0d) pop 0000", tag, xpixel_check, ypixel_check, pop, XP, YP);
          end
          stall_left--;
          stall_cyc++;
        end else begin
          tests_run++;
          if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL %s extra pixel: got data %h, required no pixel", tag, out_data);
          end else begin
            e = sb.pop_front();
            if (out_data !== e.data) begin
              tests_failed++;
              $display("FAIL %s pixel %0d data: got %h required %h", tag, hs, out_data, e.data);
            end
            tests_run++;
            if ({out_sop, out_eol, out_eop} !== {e.sop, e.eol, e.eop}) begin
              tests_failed++;
              $display("FAIL %s pixel %0d markers sop/eol/eop: got %b required %b", tag, hs, {out_sop, out_eol, out_eop}, {e.sop, e.eol, e.eop});
            end
            tests_run++;
            if (pop_acc !== e.pop || pop_cnt != ((e.pop != 4'b0) ? 1 : 0)) begin
              tests_failed++;
              $display("FAIL %s pixel %0d pop: got %b over %0d cycles, required %b once", tag, hs, pop_acc, pop_cnt, e.pop);
            end
            if (hs > 0) begin
              tests_run++;
              if (cyc - last_hs != e.gap + stall_cyc) begin
                tests_failed++;
                $display("FAIL %s pixel %0d spacing: got %0d cycles required %0d", tag, hs, cyc - last_hs, e.gap + stall_cyc);
              end
            end
          end
          hs++;
          last_hs   = cyc;
          pop_acc   = '0;
          pop_cnt   = 0;
          stall_cyc = 0;
        end
      end
    end
    tests_run++;
    if (!done_seen) begin
      tests_failed++;
      $display("FAIL %s frame budget: got no frame_done in %0d cycles, required frame_done", tag, cyc);
    end else begin
      @(negedge clk);
      if (frame_done !== 1'b0 || out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s frame_done width: got frame_done %b valid %b one cycle later, required 0 0", tag, frame_done, out_valid);
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({out_valid, out_sop, out_eol, out_eop, frame_done} !== 5'b0 || pop !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset flags: got valid/sop/eol/eop/done %b pop %b, required 00000 0000", {out_valid, out_sop, out_eol, out_eop, frame_done}, pop);
    end
    tests_run++;
    if (out_data !== 24'h0 || timeout_cnt !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset data: got out_data %h timeout_cnt %0d, required 000000 0", out_data, timeout_cnt);
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (xpixel_check !== XP || ypixel_check !== YP) begin
      tests_failed++;
      $display("FAIL reset park: got (%0d,%0d) required (%0d,%0d)", xpixel_check, ypixel_check, XP, YP);
    end
  endtask

  task automatic test_full_frame();
    en = 4'b1111;
    fill_tab(4'b0100);
    build_expected();
    drain_frame(-1, "full_frame");
  endtask

  task automatic test_priority();
    en = 4'b1111;
    fill_tab(4'b0100);
    match_tab[0] = 4'b1010;
    build_expected();
    drain_frame(-1, "priority");
  endtask

  task automatic test_timeout();
    en = 4'b1111;
    fill_tab(4'b0100);
    match_tab[1] = 4'b0000;
    build_expected();
    drain_frame(-1, "timeout");
  endtask

  task automatic test_en_gating();
    en = 4'b1110;
    fill_tab(4'b0100);
    match_tab[0] = 4'b0001;
    build_expected();
    drain_frame(-1, "en_gating");
    en = 4'b1111;
  endtask

  task automatic test_backpressure();
    en = 4'b1111;
    fill_tab(4'b0100);
    match_tab[3] = 4'b1000;
    build_expected();
    drain_frame(3, "backpressure");
  endtask

  task automatic test_reset_mid_frame();
    bit found = 1'b0;
    bit leak  = 1'b0;
    en = 4'b1111;
    fill_tab(4'b0100);
    start = 1'b1;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (xpixel_check == 10'd2 && ypixel_check == 10'd1) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL midreset reach (2,1): got (%0d,%0d) required (2,1)", xpixel_check, ypixel_check);
    end else begin
      if (pop !== 4'b0100) begin
        tests_failed++;
        $display("FAIL midreset pop before reset: got %b required 0100", pop);
      end
      reset = 1'b1;
      #1;
      tests_run++;
      if (pop !== 4'b0) begin
        tests_failed++;
        $display("FAIL midreset pop during reset: got %b required 0000", pop);
      end
      @(negedge clk);
      tests_run++;
      if ({out_valid, out_sop, out_eol, out_eop, frame_done} !== 5'b0 || out_data !== 24'h0 ||
          timeout_cnt !== 16'h0 || xpixel_check !== XP || ypixel_check !== YP) begin
        tests_failed++;
        $display("FAIL midreset outputs: got flags %b data %h tcnt %0d bus (%0d,%0d), required 00000 000000 0 (%0d,%0d)",
                 {out_valid, out_sop, out_eol, out_eop, frame_done}, out_data, timeout_cnt, xpixel_check, ypixel_check, XP, YP);
      end
      reset = 1'b0;
      repeat (5) begin
        @(negedge clk);
        if (frame_done !== 1'b0 || out_valid !== 1'b0 || out_eop !== 1'b0) leak = 1'b1;
      end
      tests_run++;
      if (leak) begin
        tests_failed++;
        $display("FAIL midreset abandon: got valid/eop/frame_done activity after reset, required none");
      end
    end
    build_expected();
    drain_frame(-1, "restart");
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    en        = 4'b1111;
    out_ready = 1'b1;
    fill_tab(4'b0000);
    test_reset();
    test_full_frame();
    test_priority();
    test_timeout();
    test_en_gating();
    test_backpressure();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at 200000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
